// File: rtl/hsync_line_decoder_if.sv
// hsync_line_decoder_if
// Groups the sync-source side and the recovered-timing side of the
// horizontal sync decoder.
//   pixel_clock, hsync           : incoming pixel clock and horizontal sync
//   back_porch, active_video     : expected porch / active widths, in ticks
//   line_start, locked           : lead-edge pulse and timing-stable flag
//   video_active, xposition      : recovered active window and pixel index
//   measured_sync, measured_line : last measured sync width / line length
// master drives the source side, slave is the decoder.
interface hsync_line_decoder_if #(
    parameter int XRES = 10
);
    logic            pixel_clock;
    logic            hsync;
    logic [XRES-1:0] back_porch;
    logic [XRES-1:0] active_video;
    logic            line_start;
    logic            locked;
    logic            video_active;
    logic [XRES-1:0] xposition;
    logic [XRES-1:0] measured_sync;
    logic [XRES-1:0] measured_line;

    modport master (
        output pixel_clock, hsync, back_porch, active_video,
        input  line_start, locked, video_active, xposition,
               measured_sync, measured_line
    );

    modport slave (
        input  pixel_clock, hsync, back_porch, active_video,
        output line_start, locked, video_active, xposition,
               measured_sync, measured_line
    );
endinterface

// File: rtl/hsync_line_decoder.sv
// hsync_line_decoder
// Samples hsync on pixel-clock ticks, measures sync width and line length,
// locks after LOCK_LINES identical lines and recovers the active-video
// window and pixel position.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : hsync_line_decoder_if.slave (see interface header)
//
// state  | meaning
// SEARCH | no line reference; waiting for a sync leading edge
// SYNC   | inside the sync pulse, timing its width
// LINE   | after the sync pulse, timing up to the next leading edge
module hsync_line_decoder #(
    parameter int XRES       = 10,
    parameter int LOCK_LINES = 3,
    parameter bit SYNC_HIGH  = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    hsync_line_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SYNC,
        ST_LINE
    } state_t;

    localparam logic [XRES-1:0] CNT_MAX = '1;
    localparam logic [3:0]      LOCK_N  = 4'(LOCK_LINES);

    state_t          state_q, state_d;
    logic            pc_q;
    logic            hs_q;
    logic [XRES-1:0] cnt_q, cnt_d;
    logic [XRES-1:0] ms_q, ms_d;
    logic [XRES-1:0] ml_q, ml_d;
    logic [XRES-1:0] ref_sync_q, ref_sync_d;
    logic            have_ref_q, have_ref_d;
    logic [3:0]      match_q, match_d;
    logic            locked_q, locked_d;
    logic            va_q, va_d;
    logic [XRES-1:0] xpos_q, xpos_d;
    logic            ls_q;

    logic            s;
    logic            tick;
    logic            lead;
    logic            trail;
    logic            sat;
    logic [XRES-1:0] p;
    logic [XRES-1:0] a0;
    logic [XRES-1:0] rel;

    assign s     = SYNC_HIGH ? bus.hsync : ~bus.hsync;
    assign tick  = bus.pixel_clock & ~pc_q;
    assign lead  = tick & s & ~hs_q;
    assign trail = tick & ~s & hs_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ms_d       = ms_q;
        ml_d       = ml_q;
        ref_sync_d = ref_sync_q;
        have_ref_d = have_ref_q;
        match_d    = match_q;
        locked_d   = locked_q;
        va_d       = va_q;
        xpos_d     = xpos_q;
        sat        = 1'b0;
        p          = '0;
        a0         = '0;
        rel        = '0;

        if (tick) begin
            if (lead)
                cnt_d = {{(XRES-1){1'b0}}, 1'b1};
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;

            // a lead always reloads the counter, so it can never saturate
            sat = ~lead & (cnt_d == CNT_MAX);

            unique case (state_q)
                ST_SEARCH: begin
                    if (lead)
                        state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (sat) begin
                        state_d    = ST_SEARCH;
                        locked_d   = 1'b0;
                        match_d    = '0;
                        have_ref_d = 1'b0;
                    end else if (trail) begin
                        ms_d    = cnt_q;
                        state_d = ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (lead) begin
                        ml_d       = cnt_q;
                        ref_sync_d = ms_q;
                        have_ref_d = 1'b1;
                        state_d    = ST_SYNC;
                        if (!have_ref_q) begin
                            // first measured line: nothing to compare against yet
                            match_d  = 4'd1;
                            locked_d = (LOCK_N == 4'd1);
                        end else if (cnt_q == ml_q && ms_q == ref_sync_q) begin
                            if (match_q < LOCK_N)
                                match_d = match_q + 4'd1;
                            locked_d = locked_q | (match_d == LOCK_N);
                        end else begin
                            match_d  = 4'd1;
                            locked_d = 1'b0;
                        end
                    end else if (sat) begin
                        state_d    = ST_SEARCH;
                        locked_d   = 1'b0;
                        match_d    = '0;
                        have_ref_d = 1'b0;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase

            // position within the line counts from 0 at the leading-edge tick
            p      = cnt_d - 1'b1;
            a0     = ms_d + bus.back_porch;
            rel    = p - a0;
            va_d   = locked_d & (p >= a0) & (rel < bus.active_video);
            xpos_d = va_d ? rel : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            pc_q       <= 1'b1;
            hs_q       <= 1'b1;
            cnt_q      <= '0;
            ms_q       <= '0;
            ml_q       <= '0;
            ref_sync_q <= '0;
            have_ref_q <= 1'b0;
            match_q    <= '0;
            locked_q   <= 1'b0;
            va_q       <= 1'b0;
            xpos_q     <= '0;
            ls_q       <= 1'b0;
        end else begin
            pc_q       <= bus.pixel_clock;
            ls_q       <= lead;
            if (tick)
                hs_q <= s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ms_q       <= ms_d;
            ml_q       <= ml_d;
            ref_sync_q <= ref_sync_d;
            have_ref_q <= have_ref_d;
            match_q    <= match_d;
            locked_q   <= locked_d;
            va_q       <= va_d;
            xpos_q     <= xpos_d;
        end
    end

    assign bus.line_start    = ls_q;
    assign bus.locked        = locked_q;
    assign bus.video_active  = va_q;
    assign bus.xposition     = xpos_q;
    assign bus.measured_sync = ms_q;
    assign bus.measured_line = ml_q;
endmodule

// File: tb/tb_hsync_line_decoder.sv
// tb_hsync_line_decoder
// Directed bench for hsync_line_decoder: 2-unit system clock, 8-unit pixel
// clock, lines of sync 3 / back porch 4 / active 6 / front porch 2 ticks.
module tb_hsync_line_decoder;
    logic clock;
    logic reset;
    bit   clk_en = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ls_seen = 0;

    hsync_line_decoder_if #(.XRES(10)) bus ();

    hsync_line_decoder #(
        .XRES(10),
        .LOCK_LINES(3),
        .SYNC_HIGH(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever begin
            #1;
            if (clk_en)
                clock = ~clock;
        end
    end

    initial begin
        bus.pixel_clock = 1'b0;
        forever #4 bus.pixel_clock = ~bus.pixel_clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive hsync for one tick; outputs are sampled on the falling clock edge
    // just after the tick edge.
    task automatic do_tick(input logic hs);
        @(posedge bus.pixel_clock);
        bus.hsync = hs;
        #2;
        if (bus.line_start === 1'b1)
            ls_seen++;
    endtask

    task automatic run_line(input int sync_w, input int len, input logic exp_lock,
                            input bit chk_win);
        logic exp_va;
        for (int i = 0; i < len; i++) begin
            do_tick(i < sync_w);
            if (i == 0) begin
                check("line_start", bus.line_start, 1);
                check("locked_at_lead", bus.locked, exp_lock);
                #2;
                check("line_start_width", bus.line_start, 0);
            end
            if (chk_win) begin
                exp_va = exp_lock && (i >= 7) && (i <= 12);
                check("video_active", bus.video_active, exp_va);
                check("xposition", bus.xposition, exp_va ? i - 7 : 0);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.hsync        = 1'b1;
        bus.back_porch   = 10'd4;
        bus.active_video = 10'd6;

        #5;
        check("rst_line_start", bus.line_start, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_video_active", bus.video_active, 0);
        check("rst_xposition", bus.xposition, 0);
        check("rst_measured_sync", bus.measured_sync, 0);
        check("rst_measured_line", bus.measured_line, 0);
        #5;
        reset = 1'b0;

        // hsync already asserted at reset release is not a leading edge
        ls_seen = 0;
        repeat (4) do_tick(1'b1);
        check("no_lead_held_high", ls_seen, 0);
        repeat (3) do_tick(1'b0);
        check("no_lead_after_low", ls_seen, 0);

        // first lead comes from SEARCH, then three measured lines to lock
        run_line(3, 15, 1'b0, 1'b0);
        run_line(3, 15, 1'b0, 1'b0);
        run_line(3, 15, 1'b0, 1'b1);
        run_line(3, 15, 1'b1, 1'b1);
        check("measured_sync", bus.measured_sync, 3);
        check("measured_line", bus.measured_line, 15);

        // a single long line drops lock at the lead that measures it
        run_line(3, 16, 1'b1, 1'b1);
        run_line(3, 15, 1'b0, 1'b1);
        check("measured_line_long", bus.measured_line, 16);
        run_line(3, 15, 1'b0, 1'b0);
        run_line(3, 15, 1'b0, 1'b0);
        run_line(3, 15, 1'b1, 1'b1);
        check("measured_line_relock", bus.measured_line, 15);

        // hsync stays inactive until the counter saturates at tick 1022
        ls_seen = 0;
        for (int j = 0; j < 1100; j++) begin
            do_tick(1'b0);
            if (j + 15 == 1021)
                check("locked_before_sat", bus.locked, 1);
            if (j + 15 == 1022) begin
                check("locked_at_sat", bus.locked, 0);
                check("video_active_at_sat", bus.video_active, 0);
            end
        end
        check("no_lead_while_idle", ls_seen, 0);
        check("locked_idle", bus.locked, 0);

        // lead from SEARCH stores no line measurement
        run_line(3, 15, 1'b0, 1'b0);
        check("measured_line_after_search", bus.measured_line, 15);
        run_line(3, 15, 1'b0, 1'b0);
        run_line(3, 15, 1'b0, 1'b0);
        run_line(3, 15, 1'b1, 1'b1);

        // reset in the middle of active video, with the clock stopped
        for (int i = 0; i < 10; i++)
            do_tick(i < 3);
        check("mid_video_active", bus.video_active, 1);
        check("mid_xposition", bus.xposition, 2);
        clk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_locked", bus.locked, 0);
        check("async_video_active", bus.video_active, 0);
        check("async_xposition", bus.xposition, 0);
        check("async_line_start", bus.line_start, 0);
        check("async_measured_sync", bus.measured_sync, 0);
        check("async_measured_line", bus.measured_line, 0);
        clk_en = 1'b1;
        #4;
        reset = 1'b0;
        #4;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
